// File: rtl/eater_pkg.sv
// ============================================================================
// Module      : eater_pkg
// Description : Shared constants and types for the 8-bit computer's RAM
//               subsystem (RAM, programming path, dump reader).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eater_pkg;

   // RAM geometry and frame header shared by RAM, programmer and reader
   localparam int         RAM_ADDR_W = 4;
   localparam int         RAM_DEPTH  = 1 << RAM_ADDR_W;
   localparam int         RAM_DATA_W = 8;
   localparam logic [7:0] RAM_HEADER = 8'hA5;

   // Dump reader FSM states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_SEND = 3'd4,
      ST_SUM  = 3'd5
   } dump_state_t;

endpackage : eater_pkg

`default_nettype wire

// File: rtl/ram_dump_reader.sv
// ============================================================================
// Module      : ram_dump_reader
// Description : Reads a contiguous, wrapping range of RAM through a
//               one-cycle-latency read port and streams it out as a frame:
//               header byte, data bytes, 8-bit checksum of the data bytes.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start, base_addr,
//               length                - dump request (length 0 means full RAM)
//               ram_re, ram_addr,
//               ram_rdata             - RAM read port (data one cycle later)
//               out_data, out_valid,
//               out_ready             - valid/ready byte stream
//               busy, done            - frame in progress / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dump_reader
   import eater_pkg::*;
#(
   parameter int                ADDR_W = RAM_ADDR_W,
   parameter int                DATA_W = RAM_DATA_W,
   parameter logic [DATA_W-1:0] HEADER = DATA_W'(RAM_HEADER)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0]   ONE_LEN  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

   dump_state_t       state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [ADDR_W:0]   rem_q,      rem_d;
   logic [DATA_W-1:0] sum_q,      sum_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              done_q,     done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         sum_q      <= '0;
         out_data_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         sum_q      <= sum_d;
         out_data_q <= out_data_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      sum_d      = sum_q;
      out_data_d = out_data_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The FSM is already back in IDLE while done is high; a start
            // overlapping the done pulse belongs to the finished frame.
            if (start && !done_q) begin
               addr_d     = base_addr;
               rem_d      = (length == '0) ? FULL_LEN : length;
               sum_d      = '0;
               out_data_d = HEADER;
               state_d    = ST_HDR;
            end
         end
         ST_HDR: begin
            if (out_ready) state_d = ST_RD;
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            out_data_d = ram_rdata;
            sum_d      = sum_q + ram_rdata;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               rem_d  = rem_q - ONE_LEN;
               addr_d = addr_q + ONE_ADDR;
               if (rem_q == ONE_LEN) begin
                  // sum_q already includes this last byte (added in CAP)
                  out_data_d = sum_q;
                  state_d    = ST_SUM;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_SUM: begin
            if (out_ready) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode directly from registered state so an async reset clears
   // them immediately.
   assign ram_re    = (state_q == ST_RD);
   assign ram_addr  = addr_q;
   assign out_data  = out_data_q;
   assign out_valid = (state_q == ST_HDR) || (state_q == ST_SEND) || (state_q == ST_SUM);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule : ram_dump_reader

`default_nettype wire
